// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: default widths, register map and
// counter direction encoding.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 16;
    localparam int unsigned PWM_PRE_W = 8;

    // Register block address map (byte addresses)
    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_STATUS     = 8'h01;
    localparam logic [7:0] ADDR_PERIOD_L   = 8'h02;
    localparam logic [7:0] ADDR_PERIOD_H   = 8'h03;
    localparam logic [7:0] ADDR_PRESCALE   = 8'h04;
    localparam logic [7:0] ADDR_DUTY_L     = 8'h05;
    localparam logic [7:0] ADDR_DUTY_H     = 8'h06;
    localparam logic [7:0] ADDR_CNT_L      = 8'h08;
    localparam logic [7:0] ADDR_CNT_H      = 8'h09;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler for the PWM timebase: emits a tick once every prescale+1 enabled clocks.
module pwm_prescaler #(
    parameter int unsigned PRE_W = pwm_pkg::PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_hit;

    // >= rather than == so that lowering prescale mid-run never waits for a full rollover
    assign w_hit = (r_pre_cnt >= prescale);
    assign tick  = en & ~clear & w_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (clear) begin
            r_pre_cnt <= '0;
        end else if (en) begin
            r_pre_cnt <= w_hit ? '0 : r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: prescaled up/down counter over 0..period with a registered
// one-cycle wrap pulse at each period boundary.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = pwm_pkg::PWM_CNT_W,
    parameter int unsigned PRE_W = pwm_pkg::PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [CNT_W-1:0] counter_val,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;
    logic             w_tick;
    dir_e             w_dir;

    assign w_dir = dir_e'(upnotdown);

    pwm_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clear    (count_reset),
        .prescale (prescale),
        .tick     (w_tick)
    );

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (count_reset) begin
            w_cnt_nxt = (w_dir == DIR_UP) ? '0 : period;
        end else if (w_tick) begin
            if (w_dir == DIR_UP) begin
                if (r_cnt >= period) begin
                    w_cnt_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else begin
                // Zero check first so period=0 still pulses wrap; clamp after period shrinks
                if (r_cnt == '0) begin
                    w_cnt_nxt  = period;
                    w_wrap_nxt = 1'b1;
                end else if (r_cnt > period) begin
                    w_cnt_nxt = period;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign counter_val = r_cnt;
    assign wrap        = r_wrap;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter with hand-computed expected counts and wrap pulses.
module tb_pwm_counter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        count_reset;
    logic        upnotdown;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] counter_val;
    logic        wrap;

    int unsigned n_tests;
    int unsigned n_fail;

    pwm_counter #(
        .CNT_W (16),
        .PRE_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .counter_val (counter_val),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_cnt, input logic exp_wrap);
        n_tests++;
        assert (counter_val === exp_cnt && wrap === exp_wrap)
        else begin
            n_fail++;
            $error("FAIL %s: counter_val=%0d wrap=%b, expected counter_val=%0d wrap=%b",
                   tag, counter_val, wrap, exp_cnt, exp_wrap);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        count_reset = 1'b0;
        upnotdown   = 1'b1;
        period      = 16'd5;
        prescale    = 8'd0;

        // Reset held with en=1
        step(); chk("reset_c1", 16'd0, 1'b0);
        step(); chk("reset_c2", 16'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b0;
        step(); chk("post_reset_idle1", 16'd0, 1'b0);
        step(); chk("post_reset_idle2", 16'd0, 1'b0);

        // Up count, period=3
        period = 16'd3;
        en     = 1'b1;
        step(); chk("up_1", 16'd1, 1'b0);
        step(); chk("up_2", 16'd2, 1'b0);
        step(); chk("up_3", 16'd3, 1'b0);
        step(); chk("up_wrap0", 16'd0, 1'b1);
        step(); chk("up_1b", 16'd1, 1'b0);

        // Prescale=2, period=2
        prescale    = 8'd2;
        period      = 16'd2;
        count_reset = 1'b1;
        step(); chk("pre_reset", 16'd0, 1'b0);
        count_reset = 1'b0;
        step(); chk("pre_0a", 16'd0, 1'b0);
        step(); chk("pre_0b", 16'd0, 1'b0);
        step(); chk("pre_1a", 16'd1, 1'b0);
        step(); chk("pre_1b", 16'd1, 1'b0);
        step(); chk("pre_1c", 16'd1, 1'b0);
        step(); chk("pre_2a", 16'd2, 1'b0);
        step(); chk("pre_2b", 16'd2, 1'b0);
        step(); chk("pre_2c", 16'd2, 1'b0);
        step(); chk("pre_wrap0", 16'd0, 1'b1);
        step(); chk("pre_0_nowrap", 16'd0, 1'b0);

        // Down count, period=4
        prescale    = 8'd0;
        upnotdown   = 1'b0;
        period      = 16'd4;
        count_reset = 1'b1;
        step(); chk("dn_reload", 16'd4, 1'b0);
        count_reset = 1'b0;
        step(); chk("dn_3", 16'd3, 1'b0);
        step(); chk("dn_2", 16'd2, 1'b0);
        step(); chk("dn_1", 16'd1, 1'b0);
        step(); chk("dn_0", 16'd0, 1'b0);
        step(); chk("dn_wrap4", 16'd4, 1'b1);
        step(); chk("dn_3b", 16'd3, 1'b0);

        // period=0, both directions
        upnotdown   = 1'b1;
        period      = 16'd0;
        count_reset = 1'b1;
        step(); chk("p0_reset", 16'd0, 1'b0);
        count_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("p0_up", 16'd0, 1'b1);
        end
        upnotdown = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); chk("p0_dn", 16'd0, 1'b1);
        end

        // Up mode at 9, period 10 -> 5
        upnotdown   = 1'b1;
        period      = 16'd10;
        count_reset = 1'b1;
        step();
        count_reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("up_at9", 16'd9, 1'b0);
        period = 16'd5;
        step(); chk("up_shrink_wrap", 16'd0, 1'b1);

        // Down mode at 9, period changed to 5 -> clamp
        period      = 16'd10;
        count_reset = 1'b1;
        step();
        count_reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("dn_prep_at9", 16'd9, 1'b0);
        upnotdown = 1'b0;
        period    = 16'd5;
        step(); chk("dn_clamp5", 16'd5, 1'b0);
        step(); chk("dn_after_clamp", 16'd4, 1'b0);

        // Enable drop at 7
        upnotdown   = 1'b1;
        period      = 16'd20;
        count_reset = 1'b1;
        step();
        count_reset = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("en_at7", 16'd7, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(); chk("en_hold7", 16'd7, 1'b0);
        end
        en = 1'b1;
        step(); chk("en_resume8", 16'd8, 1'b0);

        // count_reset held 2 cycles with en=1; prescaler left mid-count first
        prescale = 8'd2;
        step(); chk("cr_pre_mid", 16'd8, 1'b0);
        count_reset = 1'b1;
        step(); chk("cr_hold1", 16'd0, 1'b0);
        step(); chk("cr_hold2", 16'd0, 1'b0);
        count_reset = 1'b0;
        step(); chk("cr_pre0", 16'd0, 1'b0);
        step(); chk("cr_pre1", 16'd0, 1'b0);
        step(); chk("cr_tick", 16'd1, 1'b0);

        // Direction change mid-run without reload
        prescale  = 8'd0;
        upnotdown = 1'b0;
        step(); chk("dir_flip_dn", 16'd0, 1'b0);
        step(); chk("dir_flip_wrap", 16'd20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
